// File: rtl/f1_pkg.sv
// Shared types and constants for the reaction timer.
package f1_pkg;

    // Width of the millisecond count and latched result (feeds a 16-bit bin-to-BCD).
    localparam int MS_W = 16;

    // State encodings, kept as plain constants so older code can match on them.
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ARMED  = 3'd1;
    localparam logic [2:0] ST_TIMING = 3'd2;
    localparam logic [2:0] ST_DONE   = 3'd3;
    localparam logic [2:0] ST_FAULT  = 3'd4;

    typedef enum logic [2:0] {
        RT_IDLE   = ST_IDLE,
        RT_ARMED  = ST_ARMED,
        RT_TIMING = ST_TIMING,
        RT_DONE   = ST_DONE,
        RT_FAULT  = ST_FAULT
    } rt_state_t;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchroniser followed by a registered rising-edge detector.
// A fill marker travels alongside the data so that a level already high when
// reset releases is treated as history rather than as a fresh edge.
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic [SYNC_STAGES:0]   fill_reg;   // bit i set: stage i (or prev_reg at SYNC_STAGES) holds a real sample
    logic                   prev_reg;
    logic                   pulse_reg;

    // Shift the input through the synchroniser and emit a one-clk pulse on each rise.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg  <= '0;
            fill_reg  <= '0;
            prev_reg  <= 1'b0;
            pulse_reg <= 1'b0;
        end else begin
            sync_reg[0] <= din;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_reg[i] <= sync_reg[i-1];
            end
            fill_reg  <= {fill_reg[SYNC_STAGES-1:0], 1'b1};
            prev_reg  <= sync_reg[SYNC_STAGES-1];
            pulse_reg <= sync_reg[SYNC_STAGES-1] & ~prev_reg & fill_reg[SYNC_STAGES];
        end
    end

    assign pulse = pulse_reg;

endmodule

// File: rtl/reaction_timer.sv
// Start-light reaction timer: measures ms from go to the driver's button press,
// flags presses before go as jump starts, and holds the result until re-armed.
import f1_pkg::*;

module reaction_timer #(
    parameter int MAX_MS      = 9999,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            tick_ms,
    input  logic            arm,
    input  logic            go,
    input  logic            react,
    output logic [MS_W-1:0] time_ms,
    output logic            valid,
    output logic            jump_start,
    output logic            busy
);

    localparam logic [MS_W-1:0] MAX_VAL = MS_W'(MAX_MS);

    logic            press;
    rt_state_t       state_reg, state_next;
    logic [MS_W-1:0] count_reg, count_next, count_inc;
    logic [MS_W-1:0] time_reg, time_next;
    logic            valid_reg, valid_next;
    logic            jump_reg, jump_next;

    sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_react_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (react),
        .pulse (press)
    );

    // Next-state, counter and result logic; press takes priority over go in ARMED.
    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        time_next  = time_reg;
        valid_next = valid_reg;
        jump_next  = jump_reg;
        count_inc  = (tick_ms && (count_reg < MAX_VAL)) ? count_reg + 1'b1 : count_reg;

        case (state_reg)
            RT_IDLE: begin
                if (arm) state_next = RT_ARMED;
            end
            RT_ARMED: begin
                if (press) begin
                    state_next = RT_FAULT;
                    time_next  = '0;
                    valid_next = 1'b1;
                    jump_next  = 1'b1;
                end else if (go) begin
                    state_next = RT_TIMING;
                    count_next = '0;
                end
            end
            RT_TIMING: begin
                count_next = count_inc;
                if (press) begin
                    state_next = RT_DONE;
                    time_next  = count_inc;
                    valid_next = 1'b1;
                    jump_next  = 1'b0;
                end
            end
            RT_DONE, RT_FAULT: begin
                if (arm) begin
                    state_next = RT_ARMED;
                    valid_next = 1'b0;
                    jump_next  = 1'b0;
                end
            end
            default: state_next = RT_IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= RT_IDLE;
            count_reg <= '0;
            time_reg  <= '0;
            valid_reg <= 1'b0;
            jump_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            time_reg  <= time_next;
            valid_reg <= valid_next;
            jump_reg  <= jump_next;
        end
    end

    assign time_ms    = time_reg;
    assign valid      = valid_reg;
    assign jump_start = jump_reg;
    assign busy       = (state_reg == RT_ARMED) || (state_reg == RT_TIMING);

endmodule

// File: tb/tb_reaction_timer.sv
// Scenario bench for reaction_timer: expected results are queued when a
// measurement is set up and compared when valid rises.
module tb_reaction_timer;

    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tick_ms = 1'b0;
    logic        arm = 1'b0;
    logic        go = 1'b0;
    logic        react = 1'b0;
    logic [15:0] time_ms;
    logic        valid;
    logic        jump_start;
    logic        busy;

    typedef struct {
        logic [15:0] t;
        logic        j;
    } exp_t;

    exp_t sb_q[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   wcyc;
    bit   wok;

    reaction_timer #(.MAX_MS(9999), .SYNC_STAGES(SYNC)) dut (
        .clk        (clk),
        .rst        (rst),
        .tick_ms    (tick_ms),
        .arm        (arm),
        .go         (go),
        .react      (react),
        .time_ms    (time_ms),
        .valid      (valid),
        .jump_start (jump_start),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            tick_ms = 1'b1; cyc();
            tick_ms = 1'b0; cyc();
        end
    endtask

    task automatic pulse_arm();
        arm = 1'b1; cyc(); arm = 1'b0;
    endtask

    task automatic pulse_go();
        go = 1'b1; cyc(); go = 1'b0;
    endtask

    task automatic release_react();
        react = 1'b0;
        repeat (SYNC + 3) cyc();
    endtask

    // Waits (bounded) for valid; does no comparing itself.
    task automatic wait_valid(input int budget, output int cycles, output bit ok);
        ok = 1'b0;
        cycles = 0;
        while (cycles < budget && !ok) begin
            cyc();
            cycles++;
            if (valid === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; cyc(); cyc(); rst = 1'b0;
        n_cmp++; if (time_ms !== 16'd0) begin n_bad++; $display("FAIL reset_time got=%0d exp=0", time_ms); end
        n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b exp=0", valid); end
        n_cmp++; if (jump_start !== 1'b0) begin n_bad++; $display("FAIL reset_jump got=%b exp=0", jump_start); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        $display("txn reset: time=%0d valid=%b jump=%b busy=%b", time_ms, valid, jump_start, busy);
    endtask

    task automatic test_measure();
        pulse_arm();
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL armed_busy got=%b exp=1", busy); end
        pulse_go();
        tick_n(100);
        pulse_go();          // ignored while timing
        pulse_arm();         // ignored while timing
        tick_n(137);
        sb_q.push_back('{t: 16'd237, j: 1'b0});
        react = 1'b1;
        wait_valid(20, wcyc, wok);
        n_cmp++;
        if (!wok) begin n_bad++; $display("FAIL measure_timeout got=no_valid exp=valid"); end
        else if (wcyc !== SYNC + 2) begin n_bad++; $display("FAIL latency got=%0d exp=%0d", wcyc, SYNC + 2); end
        e = sb_q.pop_front();
        n_cmp++; if (time_ms !== e.t) begin n_bad++; $display("FAIL measure_time got=%0d exp=%0d", time_ms, e.t); end
        n_cmp++; if (jump_start !== e.j) begin n_bad++; $display("FAIL measure_jump got=%b exp=%b", jump_start, e.j); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL done_busy got=%b exp=0", busy); end
        $display("txn measure: time=%0d valid=%b jump=%b latency=%0d", time_ms, valid, jump_start, wcyc);
        release_react();
        pulse_arm();
        n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL rearm_valid got=%b exp=0", valid); end
        n_cmp++; if (time_ms !== 16'd237) begin n_bad++; $display("FAIL rearm_hold got=%0d exp=237", time_ms); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rearm_busy got=%b exp=1", busy); end
        $display("txn rearm: time=%0d valid=%b busy=%b", time_ms, valid, busy);
    endtask

    task automatic test_jump_start();
        pulse_arm();
        sb_q.push_back('{t: 16'd0, j: 1'b1});
        react = 1'b1;
        wait_valid(20, wcyc, wok);
        n_cmp++; if (!wok) begin n_bad++; $display("FAIL jump_timeout got=no_valid exp=valid"); end
        e = sb_q.pop_front();
        n_cmp++; if (time_ms !== e.t) begin n_bad++; $display("FAIL jump_time got=%0d exp=%0d", time_ms, e.t); end
        n_cmp++; if (jump_start !== e.j) begin n_bad++; $display("FAIL jump_flag got=%b exp=%b", jump_start, e.j); end
        release_react();
        pulse_go();
        cyc();
        n_cmp++; if (valid !== 1'b1 || jump_start !== 1'b1 || busy !== 1'b0)
            begin n_bad++; $display("FAIL fault_hold got=v%b j%b b%b exp=v1 j1 b0", valid, jump_start, busy); end
        $display("txn jump_start: time=%0d valid=%b jump=%b busy=%b", time_ms, valid, jump_start, busy);
    endtask

    task automatic test_saturate();
        pulse_arm();
        pulse_go();
        tick_n(12000);
        sb_q.push_back('{t: 16'd9999, j: 1'b0});
        react = 1'b1;
        wait_valid(20, wcyc, wok);
        n_cmp++; if (!wok) begin n_bad++; $display("FAIL sat_timeout got=no_valid exp=valid"); end
        e = sb_q.pop_front();
        n_cmp++; if (time_ms !== e.t) begin n_bad++; $display("FAIL sat_time got=%0d exp=%0d", time_ms, e.t); end
        $display("txn saturate: time=%0d valid=%b jump=%b", time_ms, valid, jump_start);
        release_react();
    endtask

    task automatic test_held();
        react = 1'b1;
        repeat (4) cyc();
        pulse_arm();
        pulse_go();
        tick_n(50);
        react = 1'b0;
        tick_n(30);
        sb_q.push_back('{t: 16'd80, j: 1'b0});
        react = 1'b1;
        wait_valid(20, wcyc, wok);
        n_cmp++; if (!wok) begin n_bad++; $display("FAIL held_timeout got=no_valid exp=valid"); end
        e = sb_q.pop_front();
        n_cmp++; if (time_ms !== e.t) begin n_bad++; $display("FAIL held_time got=%0d exp=%0d", time_ms, e.t); end
        n_cmp++; if (jump_start !== e.j) begin n_bad++; $display("FAIL held_jump got=%b exp=%b", jump_start, e.j); end
        $display("txn held: time=%0d valid=%b jump=%b", time_ms, valid, jump_start);
        release_react();
    endtask

    task automatic test_same_clk();
        // Press pulse reaches the FSM SYNC+2 edges after react rises; align go with it.
        pulse_arm();
        react = 1'b1;
        repeat (SYNC + 1) cyc();
        go = 1'b1; cyc(); go = 1'b0;
        sb_q.push_back('{t: 16'd0, j: 1'b1});
        wait_valid(20, wcyc, wok);
        n_cmp++; if (!wok) begin n_bad++; $display("FAIL samego_timeout got=no_valid exp=valid"); end
        e = sb_q.pop_front();
        n_cmp++; if (jump_start !== e.j || time_ms !== e.t)
            begin n_bad++; $display("FAIL samego got=j%b t%0d exp=j%b t%0d", jump_start, time_ms, e.j, e.t); end
        $display("txn same_go: time=%0d valid=%b jump=%b", time_ms, valid, jump_start);
        release_react();

        pulse_arm();
        pulse_go();
        tick_n(4);
        react = 1'b1;
        repeat (SYNC + 1) cyc();
        tick_ms = 1'b1; cyc(); tick_ms = 1'b0;
        sb_q.push_back('{t: 16'd5, j: 1'b0});
        wait_valid(20, wcyc, wok);
        n_cmp++; if (!wok) begin n_bad++; $display("FAIL sametick_timeout got=no_valid exp=valid"); end
        e = sb_q.pop_front();
        n_cmp++; if (time_ms !== e.t) begin n_bad++; $display("FAIL sametick_time got=%0d exp=%0d", time_ms, e.t); end
        n_cmp++; if (jump_start !== e.j) begin n_bad++; $display("FAIL sametick_jump got=%b exp=%b", jump_start, e.j); end
        $display("txn same_tick: time=%0d valid=%b jump=%b", time_ms, valid, jump_start);
        release_react();
    endtask

    task automatic test_rst_abort();
        pulse_arm();
        pulse_go();
        tick_n(100);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL timing_busy got=%b exp=1", busy); end
        rst = 1'b1; cyc(); rst = 1'b0;
        n_cmp++; if (time_ms !== 16'd0 || valid !== 1'b0 || jump_start !== 1'b0 || busy !== 1'b0)
            begin n_bad++; $display("FAIL abort_outputs got=t%0d v%b j%b b%b exp=t0 v0 j0 b0", time_ms, valid, jump_start, busy); end
        react = 1'b1;
        wait_valid(20, wcyc, wok);
        n_cmp++; if (wok) begin n_bad++; $display("FAIL abort_press got=valid exp=no_valid"); end
        $display("txn rst_abort: time=%0d valid=%b busy=%b", time_ms, valid, busy);

        // Button still held through a reset: must not register as a press.
        rst = 1'b1; cyc(); rst = 1'b0;
        pulse_arm();
        pulse_go();
        wait_valid(20, wcyc, wok);
        n_cmp++; if (wok) begin n_bad++; $display("FAIL held_rst_press got=valid exp=no_valid"); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL held_rst_busy got=%b exp=1", busy); end
        $display("txn held_through_rst: valid=%b busy=%b", valid, busy);
        release_react();
        rst = 1'b1; cyc(); rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_measure();
        test_jump_start();
        test_saturate();
        test_held();
        test_same_clk();
        test_rst_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/reaction_timer.md
REACTION_TIMER -- requirements
Module: reaction_timer

Interface
REQ-001 Parameter MAX_MS, default 9999, saturation value of the millisecond count (4 BCD digits downstream).
REQ-002 Parameter SYNC_STAGES, default 2, number of synchroniser flops on the react input.
REQ-003 clk  input  1  system clock, single domain.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 tick_ms  input  1  one-clk-wide enable pulse, once per millisecond.
REQ-006 arm  input  1  one-clk pulse: light sequence has started.
REQ-007 go  input  1  one-clk pulse: all lights extinguished, the start signal.
REQ-008 react  input  1  driver button, active-high, asynchronous to clk.
REQ-009 time_ms  output  16  measured reaction time in ms, binary, held until the next arm.
REQ-010 valid  output  1  high while time_ms holds a completed measurement.
REQ-011 jump_start  output  1  high while the latched result is a jump start.
REQ-012 busy  output  1  high in ARMED or TIMING.

Function
REQ-013 The block SHALL pass react through SYNC_STAGES flops, then a rising-edge detector; only the one-clk press pulse is used internally.
REQ-014 The FSM SHALL have states IDLE, ARMED, TIMING, DONE, FAULT.
REQ-015 IDLE: arm -> ARMED; go and press are ignored.
REQ-016 ARMED: press -> FAULT (jump start); go without press -> TIMING with counter cleared to 0.
REQ-017 ARMED, press and go in the same clk: press wins -> FAULT.
REQ-018 TIMING: counter SHALL increment by 1 on each tick_ms and SHALL saturate at MAX_MS, never wrapping.
REQ-019 TIMING: press -> DONE; time_ms SHALL latch the counter value in that clk, including any tick_ms increment in the same clk.
REQ-020 TIMING: further arm or go pulses are ignored.
REQ-021 DONE: valid=1, jump_start=0; arm -> ARMED.
REQ-022 FAULT: valid=1, jump_start=1, time_ms=0; arm -> ARMED.
REQ-023 On DONE/FAULT -> ARMED, valid and jump_start SHALL clear in the first ARMED clk; time_ms SHALL hold its old value until the next latch.
REQ-024 ARMED/TIMING: arm SHALL be ignored.
REQ-025 Button held across go SHALL NOT count as a press, because only rising edges are used.
REQ-026 Latency from react rising edge to valid SHALL be SYNC_STAGES+2 clks (sync, edge detect, state register).
REQ-027 busy SHALL be combinationally decoded from the state; all other outputs SHALL be registered.

Reset
REQ-028 With rst high at a clk edge: state=IDLE, counter=0, time_ms=0, valid=0, jump_start=0, busy=0, synchroniser and edge flops=0.
REQ-029 rst asserted mid-measurement SHALL abort it with no result latched.
REQ-030 After rst deasserts, a button already held SHALL NOT produce a press pulse.

Structure
REQ-031 Package f1_pkg SHALL hold the state enum rt_state_t and the localparam MS_W=16.
REQ-032 Sub-module sync_edge (SYNC_STAGES synchroniser plus rising-edge pulse, synchronous rst) SHALL be instantiated for react.
REQ-033 time_ms SHALL be wide enough to feed the 16-bit binary-to-BCD converter directly.

Verification
REQ-034 arm, go, 237 tick_ms pulses, then press -> time_ms=237, valid=1, jump_start=0.
REQ-035 arm, press before go -> FAULT, jump_start=1, valid=1, time_ms=0; a later go is ignored.
REQ-036 arm, go, 12000 ticks without press, then press -> time_ms=9999 (saturated).
REQ-037 react held high through arm and go, released after 50 ticks, pressed again after 80 ticks -> time_ms=80.
REQ-038 rst asserted after 100 ticks in TIMING -> all outputs 0 next clk; a following press gives no valid.
REQ-039 Press on the same clk as go -> FAULT; press on the same clk as the 5th tick -> time_ms=5.
